// File: rtl/data_memory_pkg.sv
// Shared encodings and helpers for the byte-addressed data memory.
// Size codes, controller state enum and the byte-lane enable function.
package data_memory_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {CLEAR, IDLE} state_t;

   // Little-endian lane mask; the reserved size code selects no lane.
   function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] en;
      case (size)
         SZ_BYTE: en = 4'b0001 << lane;
         SZ_HALF: en = lane[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: en = 4'b1111;
         default: en = 4'b0000;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/data_memory_ctrl_align.sv
// Combinational byte-lane steering between the word array and the datapath.
// Load side extracts and extends; store side replicates data across lanes.
module mem_lane_align
   import data_memory_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        mem_unsigned,
   input  logic [31:0] rd_word,
   input  logic [31:0] wr_data,
   output logic [31:0] load_data,
   output logic [31:0] wr_word,
   output logic [3:0]  lane_en
);

   logic signed [7:0]  ld_byte;
   logic signed [15:0] ld_half;

   always_comb begin
      ld_byte   = rd_word[8*lane +: 8];
      ld_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];
      load_data = rd_word;
      case (size)
         SZ_BYTE: load_data = mem_unsigned ? 32'($unsigned(ld_byte)) : 32'(ld_byte);
         SZ_HALF: load_data = mem_unsigned ? 32'($unsigned(ld_half)) : 32'(ld_half);
         default: load_data = rd_word;
      endcase
   end

   // Replicated data lets the lane mask alone pick which bytes land.
   always_comb begin
      case (size)
         SZ_BYTE: wr_word = {4{wr_data[7:0]}};
         SZ_HALF: wr_word = {2{wr_data[15:0]}};
         default: wr_word = wr_data;
      endcase
      lane_en = lane_enable(size, lane);
   end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with registered loads, error strobe and a
// post-reset clear sweep that zeroes the array and seeds word 0.
module data_memory_ctrl
   import data_memory_pkg::*;
#(
   parameter int          DEPTH      = 32,
   parameter logic [31:0] INIT_WORD0 = 32'h0000_0FFF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] endereco,
   input  logic [1:0]  size,
   input  logic        mem_unsigned,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        read_valid,
   output logic        ready,
   output logic        erro
);

   localparam int AW = $clog2(DEPTH);

   state_t        state, state_nxt;
   logic [AW-1:0] cnt;
   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] idx;
   logic          both, one, bad, oor;
   logic          ld_ok, st_ok, err_req;
   logic [31:0]   load_data, wr_word;
   logic [3:0]    lane_en;

   assign idx   = endereco[AW+1:2];
   assign ready = (state == IDLE);

   always_comb begin
      both    = mem_read & mem_write;
      one     = mem_read ^ mem_write;
      oor     = |(endereco >> (AW + 2));
      bad     = (size == 2'b11) ||
                (size == SZ_HALF && endereco[0]) ||
                (size == SZ_WORD && endereco[1:0] != 2'b00) ||
                oor;
      ld_ok   = ready & one & mem_read  & ~bad;
      st_ok   = ready & one & mem_write & ~bad;
      err_req = ready & (both | (one & bad));
   end

   mem_lane_align u_align (
      .size         (size),
      .lane         (endereco[1:0]),
      .mem_unsigned (mem_unsigned),
      .rd_word      (mem[idx]),
      .wr_data      (write_data),
      .load_data    (load_data),
      .wr_word      (wr_word),
      .lane_en      (lane_en)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= CLEAR;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == CLEAR && cnt == AW'(DEPTH - 1))
         state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (state == CLEAR)
         cnt <= cnt + 1'b1;
   end

   // Sweep writes own the array until ready; afterwards only accepted stores.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR) begin
            mem[cnt] <= (cnt == '0) ? INIT_WORD0 : 32'h0;
         end else if (st_ok) begin
            for (int b = 0; b < 4; b++)
               if (lane_en[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         read_valid <= 1'b0;
         erro       <= 1'b0;
         read_data  <= 32'h0;
      end else begin
         read_valid <= ld_ok;
         erro       <= err_req;
         if (ld_ok) read_data <= load_data;
      end
   end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: directed vector table, sweep/reset sequences
// and randomized traffic checked against a byte-array reference model.
module tb_data_memory_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0;
   logic [31:0] endereco = 32'h0, write_data = 32'h0;
   logic [1:0]  size = 2'b10;
   logic [31:0] read_data;
   logic        read_valid, ready, erro;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  ref_mem [128];
   logic        m_valid, m_erro;
   logic [31:0] m_data;

   always #5 clk = ~clk;

   data_memory_ctrl #(.DEPTH(32), .INIT_WORD0(32'h0000_0FFF)) dut (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .endereco(endereco), .size(size), .mem_unsigned(mem_unsigned),
      .write_data(write_data), .read_data(read_data), .read_valid(read_valid),
      .ready(ready), .erro(erro)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
      {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]} = 32'h0000_0FFF;
      m_valid = 1'b0; m_erro = 1'b0; m_data = 32'h0;
   endtask

   function automatic logic is_bad(input logic [31:0] a, input logic [1:0] sz);
      int n;
      n = 1 << sz;
      if (sz == 2'b11) return 1'b1;
      if (a >= 32'd128) return 1'b1;
      return (a % n) != 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
      int n;
      logic [31:0] v;
      n = 1 << sz;
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
      if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   // One request cycle with the model ready; outputs observed 1 time unit after the edge.
   task automatic apply(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [1:0] sz, input logic u, input logic [31:0] wd);
      logic b;
      mem_read = rd; mem_write = wr; endereco = a; size = sz;
      mem_unsigned = u; write_data = wd;
      b = is_bad(a, sz);
      m_valid = rd && !wr && !b;
      m_erro  = (rd && wr) || ((rd ^ wr) && b);
      if (m_valid) m_data = model_load(a, sz, u);
      if (wr && !rd && !b)
         for (int i = 0; i < (1 << sz); i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   task automatic sweep_check(input string nm);
      for (int k = 1; k <= 32; k++) begin
         mem_write = 1'b1; endereco = 32'h0; size = 2'b10; write_data = 32'h1234_5678;
         @(posedge clk); #1;
         if (k >= 30) check({nm, "_ready"}, {31'h0, ready}, {31'h0, k == 32});
         if (k == 5 || k == 31) check({nm, "_no_erro"}, {31'h0, erro}, 32'h0);
      end
      mem_write = 1'b0;
      model_clear();
   endtask

   typedef struct {
      logic rd, wr; logic [31:0] a; logic [1:0] sz; logic u; logic [31:0] wd;
      logic ev, ee; logic [31:0] ed;
   } vec_t;
   vec_t vecs [24];

   initial begin
      vecs[0]  = '{1,0,32'h00,2'b10,0,32'h0,        1,0,32'h0000_0FFF};
      vecs[1]  = '{1,0,32'h7C,2'b10,0,32'h0,        1,0,32'h0000_0000};
      vecs[2]  = '{0,1,32'h10,2'b10,0,32'hDEAD_BEEF,0,0,32'h0000_0000};
      vecs[3]  = '{1,0,32'h10,2'b10,0,32'h0,        1,0,32'hDEAD_BEEF};
      vecs[4]  = '{0,0,32'h10,2'b10,0,32'h0,        0,0,32'hDEAD_BEEF};
      vecs[5]  = '{0,1,32'h13,2'b00,0,32'h0000_0080,0,0,32'hDEAD_BEEF};
      vecs[6]  = '{1,0,32'h13,2'b00,0,32'h0,        1,0,32'hFFFF_FF80};
      vecs[7]  = '{1,0,32'h13,2'b00,1,32'h0,        1,0,32'h0000_0080};
      vecs[8]  = '{1,0,32'h10,2'b10,0,32'h0,        1,0,32'h80AD_BEEF};
      vecs[9]  = '{1,0,32'h12,2'b01,0,32'h0,        1,0,32'hFFFF_80AD};
      vecs[10] = '{1,0,32'h11,2'b01,0,32'h0,        0,1,32'hFFFF_80AD};
      vecs[11] = '{0,1,32'h12,2'b10,0,32'h1111_1111,0,1,32'hFFFF_80AD};
      vecs[12] = '{1,0,32'h10,2'b11,0,32'h0,        0,1,32'hFFFF_80AD};
      vecs[13] = '{1,0,32'h80,2'b10,0,32'h0,        0,1,32'hFFFF_80AD};
      vecs[14] = '{0,1,32'h80,2'b10,0,32'h2222_2222,0,1,32'hFFFF_80AD};
      vecs[15] = '{1,1,32'h10,2'b10,0,32'h3333_3333,0,1,32'hFFFF_80AD};
      vecs[16] = '{0,0,32'h10,2'b10,0,32'h0,        0,0,32'hFFFF_80AD};
      vecs[17] = '{1,0,32'h10,2'b10,0,32'h0,        1,0,32'h80AD_BEEF};
      vecs[18] = '{1,0,32'h00,2'b10,0,32'h0,        1,0,32'h0000_0FFF};
      vecs[19] = '{0,1,32'h12,2'b01,0,32'h0000_1234,0,0,32'h0000_0FFF};
      vecs[20] = '{1,0,32'h12,2'b01,1,32'h0,        1,0,32'h0000_1234};
      vecs[21] = '{1,0,32'h12,2'b00,0,32'h0,        1,0,32'h0000_0034};
      vecs[22] = '{1,0,32'h11,2'b00,1,32'h0,        1,0,32'h0000_00BE};
      vecs[23] = '{1,0,32'h10,2'b01,0,32'h0,        1,0,32'hFFFF_BEEF};

      // Reset with a load pending: nothing may escape.
      reset = 1'b1; mem_read = 1'b1; endereco = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_read_data", read_data, 32'h0);
      check("rst_read_valid", {31'h0, read_valid}, 32'h0);
      check("rst_ready", {31'h0, ready}, 32'h0);
      check("rst_erro", {31'h0, erro}, 32'h0);
      mem_read = 1'b0;
      reset = 1'b0;
      sweep_check("sweep");

      for (int i = 0; i < 24; i++) begin
         apply(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].sz, vecs[i].u, vecs[i].wd);
         check($sformatf("vec%0d_valid", i), {31'h0, read_valid}, {31'h0, vecs[i].ev});
         check($sformatf("vec%0d_erro", i), {31'h0, erro}, {31'h0, vecs[i].ee});
         check($sformatf("vec%0d_data", i), read_data, vecs[i].ed);
      end

      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         logic [1:0]  sz;
         sz = 2'($urandom_range(0, 3));
         a  = 32'($urandom_range(0, 127));
         if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~32'((1 << sz) - 1);
         if ($urandom_range(0, 15) == 0) a = a | (32'h80 << $urandom_range(0, 24));
         apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, sz,
               1'($urandom_range(0, 1)), $urandom);
         check("rnd_valid", {31'h0, read_valid}, {31'h0, m_valid});
         check("rnd_erro", {31'h0, erro}, {31'h0, m_erro});
         check("rnd_data", read_data, m_data);
      end

      // Stored data must be wiped by a reset, including one that lands mid-sweep.
      apply(0, 1, 32'h10, 2'b10, 0, 32'hCAFE_F00D);
      reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("mid_sweep_ready", {31'h0, ready}, 32'h0);
      reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
      sweep_check("resweep");
      apply(1, 0, 32'h10, 2'b10, 0, 32'h0);
      check("after_rst_w10", read_data, 32'h0);
      check("after_rst_w10_valid", {31'h0, read_valid}, 32'h1);
      apply(1, 0, 32'h00, 2'b10, 0, 32'h0);
      check("after_rst_w0", read_data, 32'h0000_0FFF);
      apply(1, 0, 32'h7C, 2'b10, 0, 32'h0);
      check("after_rst_w7c", read_data, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
